controlador_carga: RTL

- Boot-time copy sequencer that loads a program image from the storage/ROM image into instruction memory before execution leaves the BIOS phase.
- Started by the BIOS-side control.
- Reads one word per transfer from a synchronous-read source and writes it into instruction memory.
- Holds the CPU stalled while the copy runs, then pulses done so the BIOS flow can halt and hand off to instruction memory.

---
 rtl/controlador_carga.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/controlador_carga.sv
// Boot-time copy sequencer: moves a program image from a synchronous-read source
// into instruction memory, two cycles per word, stalling the CPU until done pulses.
module controlador_carga #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   num_words,
    input  logic              abort,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic              stall_cpu,
    output logic              done,
    output logic [ADDR_W:0]   words_copied
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_base_q, src_base_d;
    logic [ADDR_W-1:0]   dst_base_q, dst_base_d;
    logic [ADDR_W:0]     num_words_q, num_words_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [ADDR_W:0]     words_copied_q, words_copied_d;
    logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;

    logic [ADDR_W-1:0]   idx_lo;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W:0]     idx_inc;

    // Address sums drop the carry so both sides wrap modulo 2^ADDR_W.
    always_comb begin
        idx_lo  = idx_q[ADDR_W-1:0];
        rd_addr = src_base_q + idx_lo;
        wr_addr = dst_base_q + idx_lo;
        idx_inc = idx_q + {{ADDR_W{1'b0}}, 1'b1};
    end

    always_comb begin
        state_d        = state_q;
        src_base_d     = src_base_q;
        dst_base_d     = dst_base_q;
        num_words_d    = num_words_q;
        idx_d          = idx_q;
        words_copied_d = words_copied_q;
        src_addr_d     = src_addr_q;
        mem_addr_d     = mem_addr_q;
        mem_data_d     = mem_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_base_d     = src_base;
                    dst_base_d     = dst_base;
                    num_words_d    = num_words;
                    idx_d          = '0;
                    words_copied_d = '0;
                    state_d        = (num_words == '0) ? FIN : READ;
                end
            end
            READ: begin
                src_addr_d = rd_addr;
                state_d    = abort ? IDLE : WRITE;
            end
            WRITE: begin
                // The write on the bus this cycle always lands, even when aborting.
                mem_addr_d     = wr_addr;
                mem_data_d     = src_data;
                idx_d          = idx_inc;
                words_copied_d = words_copied_q + {{ADDR_W{1'b0}}, 1'b1};
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_inc == num_words_q) begin
                    state_d = FIN;
                end else begin
                    state_d = READ;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            src_base_q     <= '0;
            dst_base_q     <= '0;
            num_words_q    <= '0;
            idx_q          <= '0;
            words_copied_q <= '0;
            src_addr_q     <= '0;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            src_base_q     <= src_base_d;
            dst_base_q     <= dst_base_d;
            num_words_q    <= num_words_d;
            idx_q          <= idx_d;
            words_copied_q <= words_copied_d;
            src_addr_q     <= src_addr_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_q     <= mem_data_d;
        end
    end

    // Buses show the live value in their active state and hold the last one elsewhere.
    always_comb begin
        src_addr     = (state_q == READ)  ? rd_addr  : src_addr_q;
        mem_addr     = (state_q == WRITE) ? wr_addr  : mem_addr_q;
        mem_data     = (state_q == WRITE) ? src_data : mem_data_q;
        mem_we       = (state_q == WRITE);
        busy         = (state_q != IDLE);
        stall_cpu    = busy;
        done         = (state_q == FIN);
        words_copied = words_copied_q;
    end

endmodule
